bemicro_cv_sysid_ext: RTL

Parametrised Avalon-MM system-identification slave, successor to the fixed two-word system ID. It returns the build ID and build timestamp, and adds the following:
- A free-running prescaled uptime counter with atomic 64-bit snapshot reads.
- Two software scratch registers with byte enables.
- A control/status register.
- A configurable fixed read latency.

It sits on the Nios II data master's peripheral bus next to the other control slaves.

---
 rtl/bemicro_cv_sysid_pkg.sv | 34 +++
 rtl/bemicro_cv_sysid_uptime.sv | 63 ++++++
 rtl/bemicro_cv_sysid_ext.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bemicro_cv_sysid_pkg.sv
// Shared constants for the extended system-ID slave: register map, CTRL bit
// positions, block revision and the byte-lane merge helper.
package bemicro_cv_sysid_pkg;

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH0  = 3'd4;
    localparam logic [2:0] ADDR_SCRATCH1  = 3'd5;
    localparam logic [2:0] ADDR_CTRL      = 3'd6;
    localparam logic [2:0] ADDR_CAPS      = 3'd7;

    localparam int CTRL_FREEZE_BIT  = 0;
    localparam int CTRL_CLEAR_BIT   = 1;
    localparam int CTRL_WRAPPED_BIT = 8;

    localparam logic [7:0] REVISION = 8'h01;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int lane = 0; lane < 4; lane++) begin
            if (be[lane]) begin
                res[lane*8 +: 8] = new_v[lane*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bemicro_cv_sysid_uptime.sv
// Prescaled free-running uptime counter with freeze/clear control, wrap
// detection and a high-word snapshot taken alongside each low-word read.
module bemicro_cv_sysid_uptime #(
    parameter int unsigned CNT_W    = 64,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        freeze,
    input  logic        clear,
    input  logic        capture,
    output logic [31:0] cnt_lo,
    output logic [31:0] snap_hi,
    output logic        wrap_pulse
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_TERM = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      snap_hi_q, snap_hi_d;
    logic [63:0]      cnt_ext;

    assign cnt_ext = 64'(cnt_q);
    assign cnt_lo  = cnt_ext[31:0];
    assign snap_hi = snap_hi_q;

    // Next count/prescaler: clear beats freeze beats increment; the snapshot
    // takes the high part of the same count value the low read returns.
    always_comb begin
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        wrap_pulse = 1'b0;
        snap_hi_d  = capture ? cnt_ext[63:32] : snap_hi_q;
        if (clear) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (!freeze) begin
            if (presc_q == PS_TERM) begin
                presc_d    = '0;
                cnt_d      = cnt_q + CNT_W'(1);
                wrap_pulse = &cnt_q;
            end else begin
                presc_d = presc_q + PS_W'(1);
            end
        end
    end

    // Counter, prescaler and snapshot registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            snap_hi_q <= '0;
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            snap_hi_q <= snap_hi_d;
        end
    end

endmodule

// File: rtl/bemicro_cv_sysid_ext.sv
// Avalon-MM system-identification slave: ID/timestamp words, uptime counter,
// scratch registers, CTRL/CAPS and a fixed-latency read response pipeline.
module bemicro_cv_sysid_ext
    import bemicro_cv_sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE     = 32'h8765_4321,
    parameter logic [31:0] TIMESTAMP    = 32'h5451_990A,
    parameter int unsigned CNT_W        = 64,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [31:0] CAPS_VALUE = {REVISION, 16'(PRESCALE - 1),
                                          6'(CNT_W - 1), 2'(READ_LATENCY)};

    logic [31:0] scratch0_q, scratch0_d;
    logic [31:0] scratch1_q, scratch1_d;
    logic        freeze_q, freeze_d;
    logic        wrapped_q, wrapped_d;
    logic        wr_ctrl, clear_pulse, wrap_pulse;
    logic [31:0] cnt_lo, snap_hi, ctrl_rd, rd_mux;

    bemicro_cv_sysid_uptime #(
        .CNT_W   (CNT_W),
        .PRESCALE(PRESCALE)
    ) u_uptime (
        .clock     (clock),
        .reset     (reset),
        .freeze    (freeze_q),
        .clear     (clear_pulse),
        .capture   (read && (address == ADDR_UPTIME_LO)),
        .cnt_lo    (cnt_lo),
        .snap_hi   (snap_hi),
        .wrap_pulse(wrap_pulse)
    );

    // Read mux over pre-edge state, so a same-cycle write is not visible.
    always_comb begin
        ctrl_rd                   = '0;
        ctrl_rd[CTRL_FREEZE_BIT]  = freeze_q;
        ctrl_rd[CTRL_WRAPPED_BIT] = wrapped_q;
        case (address)
            ADDR_ID:        rd_mux = ID_VALUE;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_UPTIME_LO: rd_mux = cnt_lo;
            ADDR_UPTIME_HI: rd_mux = snap_hi;
            ADDR_SCRATCH0:  rd_mux = scratch0_q;
            ADDR_SCRATCH1:  rd_mux = scratch1_q;
            ADDR_CTRL:      rd_mux = ctrl_rd;
            ADDR_CAPS:      rd_mux = CAPS_VALUE;
            default:        rd_mux = '0;
        endcase
    end

    // Write decode; a wrap in the same edge outranks clearing WRAPPED.
    always_comb begin
        scratch0_d  = scratch0_q;
        scratch1_d  = scratch1_q;
        wr_ctrl     = write && (address == ADDR_CTRL);
        clear_pulse = wr_ctrl && byteenable[0] && writedata[CTRL_CLEAR_BIT];
        freeze_d    = (wr_ctrl && byteenable[0]) ? writedata[CTRL_FREEZE_BIT] : freeze_q;
        wrapped_d   = wrapped_q;
        if (write && (address == ADDR_SCRATCH0)) begin
            scratch0_d = be_merge(scratch0_q, writedata, byteenable);
        end
        if (write && (address == ADDR_SCRATCH1)) begin
            scratch1_d = be_merge(scratch1_q, writedata, byteenable);
        end
        if (wrap_pulse) begin
            wrapped_d = 1'b1;
        end else if (wr_ctrl && byteenable[1] && writedata[CTRL_WRAPPED_BIT]) begin
            wrapped_d = 1'b0;
        end
    end

    // Software-visible register state.
    always_ff @(posedge clock) begin
        if (reset) begin
            scratch0_q <= '0;
            scratch1_q <= '0;
            freeze_q   <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            scratch0_q <= scratch0_d;
            scratch1_q <= scratch1_d;
            freeze_q   <= freeze_d;
            wrapped_q  <= wrapped_d;
        end
    end

    logic [READ_LATENCY:0]       chain_vld;
    logic [READ_LATENCY:0][31:0] chain_data;

    assign chain_vld[0]  = read;
    assign chain_data[0] = rd_mux;

    for (genvar i = 0; i < READ_LATENCY; i++) begin : g_stage
        logic        vld_q, vld_d;
        logic [31:0] data_q, data_d;

        // Stage data only advances with a valid so the output holds its last value.
        always_comb begin
            vld_d  = chain_vld[i];
            data_d = chain_vld[i] ? chain_data[i] : data_q;
        end

        // Response stage register; reset flushes any read in flight.
        always_ff @(posedge clock) begin
            if (reset) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else begin
                vld_q  <= vld_d;
                data_q <= data_d;
            end
        end

        assign chain_vld[i+1]  = vld_q;
        assign chain_data[i+1] = data_q;
    end

    assign readdatavalid = chain_vld[READ_LATENCY];
    assign readdata      = chain_data[READ_LATENCY];

endmodule
